cpu_datapath: RTL and testbench

Single-bus 32-bit processor datapath for the Mini-SRC-style CPU: a 16×32 general register file, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, a combinational ALU, select-and-encode logic and a 512×32 internal RAM, all joined by one 32-bit bus. The control unit, or a bench acting as one, drives per-cycle strobes. Observation ports expose internal state for verification.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_alu.sv | 53 +++++
 rtl/cpu_datapath.sv | 148 ++++++++++++++
 tb/tb_cpu_datapath.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, instruction field positions and opcodes for the datapath
package cpu_pkg;

  localparam int WORD      = 32;
  localparam int ADDR      = 9;
  localparam int NREG      = 16;
  localparam int RAM_DEPTH = 1 << ADDR;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_MSB = 18;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_MUL  = 5'b01111,
    OP_NEG  = 5'b10000,
    OP_NOT  = 5'b10001
  } opcode_e;

  function automatic logic [NREG-1:0] decode4(input logic [3:0] field);
    decode4 = {{(NREG-1){1'b0}}, 1'b1} << field;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU, A from Y and B from the bus, 64-bit result for Z
// IncPC forces B+1 regardless of the opcode so the fetch sequence can reuse the adder.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [4:0]        opcode_i,
  input  logic              inc_pc_i,
  input  logic [WORD-1:0]   a_i,
  input  logic [WORD-1:0]   b_i,
  output logic [2*WORD-1:0] result_o
);

  opcode_e                  op;
  logic [4:0]               shamt;
  logic [WORD-1:0]          lo;
  logic signed [2*WORD-1:0] a_ext;
  logic signed [2*WORD-1:0] b_ext;
  logic signed [2*WORD-1:0] prod;

  assign op    = opcode_e'(opcode_i);
  assign shamt = b_i[4:0];
  assign a_ext = {{WORD{a_i[WORD-1]}}, a_i};
  assign b_ext = {{WORD{b_i[WORD-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    lo = a_i + b_i;
    if (!inc_pc_i) begin
      case (op)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: lo = a_i + b_i;
        OP_SUB:          lo = a_i - b_i;
        OP_AND, OP_ANDI: lo = a_i & b_i;
        OP_OR, OP_ORI:   lo = a_i | b_i;
        OP_SHR:          lo = a_i >> shamt;
        OP_SHRA:         lo = $unsigned($signed(a_i) >>> shamt);
        OP_SHL:          lo = a_i << shamt;
        OP_ROR:          lo = (a_i >> shamt) | (a_i << (6'd32 - {1'b0, shamt}));
        OP_ROL:          lo = (a_i << shamt) | (a_i >> (6'd32 - {1'b0, shamt}));
        OP_NEG:          lo = '0 - b_i;
        OP_NOT:          lo = ~b_i;
        default:         lo = a_i + b_i;
      endcase
    end else begin
      lo = b_i + 32'd1;
    end
  end

  always_comb begin
    result_o = {{WORD{1'b0}}, lo};
    if (!inc_pc_i && op == OP_MUL) result_o = prod;
  end

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - single-bus datapath: register file, PC/IR/MAR/MDR/Y/Z/HI/LO, ALU, 512x32 RAM
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [15:0]      R_rd_diog,
  input  logic [15:0]      R_wrt_diog,
  input  logic             Rin,
  input  logic             R_out,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             BAout,
  input  logic             HI_out,
  input  logic             LO_out,
  input  logic             Zhi_out,
  input  logic             Zlo_out,
  input  logic             PC_out,
  input  logic             MDR_out,
  input  logic             MAR_out,
  input  logic             In_out,
  input  logic             C_out,
  input  logic             MAR_rd,
  input  logic             Zlo_rd,
  input  logic             PC_rd,
  input  logic             MDR_rd,
  input  logic             IR_rd,
  input  logic             Y_rd,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             Write,
  output logic [WORD-1:0]  BusMuxOut,
  output logic [WORD-1:0]  r3_view,
  output logic [WORD-1:0]  Y_view,
  output logic [WORD-1:0]  Zlo_view,
  output logic [WORD-1:0]  MDR_view,
  output logic [WORD-1:0]  PC_view,
  output logic [WORD-1:0]  IR_view,
  output logic [ADDR-1:0]  MAR_view,
  output logic [WORD-1:0]  C_extended_view,
  output logic [WORD-1:0]  regControl_view
);

  logic [WORD-1:0]   regs_q [NREG];
  logic [WORD-1:0]   ram_q  [RAM_DEPTH];
  logic [WORD-1:0]   pc_q, ir_q, mdr_q, y_q, hi_q, lo_q;
  logic [ADDR-1:0]   mar_q;
  logic [2*WORD-1:0] z_q;

  logic [WORD-1:0]   pc_d, mdr_d, bus, reg_val, c_ext;
  logic [2*WORD-1:0] alu_res;
  logic [3:0]        field, drive_idx;
  logic [NREG-1:0]   onehot, load_eff, drive_eff;

  always_comb begin
    field = 4'd0;
    if (Gra)      field = ir_q[RA_HI:RA_LO];
    else if (Grb) field = ir_q[RB_HI:RB_LO];
    else if (Grc) field = ir_q[RC_HI:RC_LO];
  end

  assign onehot    = decode4(field);
  assign load_eff  = R_rd_diog  | (Rin ? onehot : '0);
  assign drive_eff = R_wrt_diog | ((R_out | BAout) ? onehot : '0);

  // Lowest-numbered driver wins if several registers are enabled at once.
  always_comb begin
    drive_idx = 4'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (drive_eff[i]) drive_idx = 4'(i);
    end
  end

  // BAout turns R0 into a literal zero so base+offset addressing can omit the base.
  assign reg_val = (BAout && field == 4'd0 && drive_idx == 4'd0) ? '0 : regs_q[drive_idx];
  assign c_ext   = {{(WORD-C_MSB-1){ir_q[C_MSB]}}, ir_q[C_MSB:0]};

  always_comb begin
    bus = '0;
    if (|drive_eff)   bus = reg_val;
    else if (HI_out)  bus = hi_q;
    else if (LO_out)  bus = lo_q;
    else if (Zhi_out) bus = z_q[2*WORD-1:WORD];
    else if (Zlo_out) bus = z_q[WORD-1:0];
    else if (PC_out)  bus = pc_q;
    else if (MDR_out) bus = mdr_q;
    else if (MAR_out) bus = {{(WORD-ADDR){1'b0}}, mar_q};
    else if (In_out)  bus = '0;
    else if (C_out)   bus = c_ext;
  end

  cpu_alu u_alu (
    .opcode_i (ir_q[OP_HI:OP_LO]),
    .inc_pc_i (IncPC),
    .a_i      (y_q),
    .b_i      (bus),
    .result_o (alu_res)
  );

  always_comb begin
    pc_d = pc_q;
    if (PC_rd)      pc_d = bus;
    else if (IncPC) pc_d = pc_q + 32'd1;
  end

  assign mdr_d = Read ? ram_q[mar_q] : bus;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (load_eff[i]) regs_q[i] <= bus;
      end
      pc_q <= pc_d;
      if (IR_rd)  ir_q  <= bus;
      if (MAR_rd) mar_q <= bus[ADDR-1:0];
      if (MDR_rd) mdr_q <= mdr_d;
      if (Y_rd)   y_q   <= bus;
      if (Zlo_rd) z_q   <= alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (Write) ram_q[mar_q] <= mdr_q;
  end

  assign BusMuxOut       = bus;
  assign r3_view         = regs_q[3];
  assign Y_view          = y_q;
  assign Zlo_view        = z_q[WORD-1:0];
  assign MDR_view        = mdr_q;
  assign PC_view         = pc_q;
  assign IR_view         = ir_q;
  assign MAR_view        = mar_q;
  assign C_extended_view = c_ext;
  assign regControl_view = {drive_eff, load_eff};

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - directed self-checking bench for cpu_datapath
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] R_rd_diog, R_wrt_diog;
  logic        Rin, R_out, Gra, Grb, Grc, BAout;
  logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
  logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
  logic        IncPC, Read, Write;
  logic [31:0] BusMuxOut, r3_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view;
  logic [8:0]  MAR_view;
  logic [31:0] C_extended_view, regControl_view;

  int n_vec  = 0;
  int n_miss = 0;

  cpu_datapath dut (
    .clk(clk), .clr(clr),
    .R_rd_diog(R_rd_diog), .R_wrt_diog(R_wrt_diog),
    .Rin(Rin), .R_out(R_out), .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
    .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
    .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .BusMuxOut(BusMuxOut), .r3_view(r3_view), .Y_view(Y_view), .Zlo_view(Zlo_view),
    .MDR_view(MDR_view), .PC_view(PC_view), .IR_view(IR_view), .MAR_view(MAR_view),
    .C_extended_view(C_extended_view), .regControl_view(regControl_view)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } alu_vec_t;

  alu_vec_t vecs[16];

  task automatic clear_ctl();
    R_rd_diog = '0; R_wrt_diog = '0;
    Rin = 0; R_out = 0; Gra = 0; Grb = 0; Grc = 0; BAout = 0;
    HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
    MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
    MAR_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0;
    IncPC = 0; Read = 0; Write = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_views_zero(input string tag);
    check({tag, " bus"}, BusMuxOut, 32'h0);
    check({tag, " r3"},  r3_view,  32'h0);
    check({tag, " Y"},   Y_view,   32'h0);
    check({tag, " Zlo"}, Zlo_view, 32'h0);
    check({tag, " MDR"}, MDR_view, 32'h0);
    check({tag, " PC"},  PC_view,  32'h0);
    check({tag, " IR"},  IR_view,  32'h0);
    check({tag, " MAR"}, {23'd0, MAR_view}, 32'h0);
    check({tag, " Cext"}, C_extended_view, 32'h0);
    check({tag, " regctl"}, regControl_view, 32'h0);
  endtask

  // Builds v in Z by shift-and-increment; needs an add-class opcode in IR; clobbers Y, Z and PC.
  task automatic make_const(input logic [31:0] v);
    Y_rd = 1; tick();
    Zlo_rd = 1; tick();
    for (int i = 31; i >= 0; i--) begin
      Zlo_out = 1; Y_rd = 1; tick();
      Zlo_out = 1; Zlo_rd = 1; tick();
      if (v[i]) begin
        Zlo_out = 1; IncPC = 1; Zlo_rd = 1; tick();
      end
    end
  endtask

  task automatic write_ram(input logic [31:0] addr, input logic [31:0] data);
    make_const(addr);
    Zlo_out = 1; MAR_rd = 1; tick();
    make_const(data);
    Zlo_out = 1; MDR_rd = 1; tick();
    Write = 1; tick();
  endtask

  task automatic read_ram(input logic [31:0] addr);
    make_const(addr);
    Zlo_out = 1; MAR_rd = 1; tick();
    Read = 1; MDR_rd = 1; tick();
  endtask

  initial begin
    vecs[0]  = '{"add",    5'b00011, 32'h12345678, 32'h11111111, 32'h23456789, 32'h0};
    vecs[1]  = '{"sub",    5'b00100, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0};
    vecs[2]  = '{"and",    5'b00101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0};
    vecs[3]  = '{"andi",   5'b01101, 32'hFFFF0000, 32'h12345678, 32'h12340000, 32'h0};
    vecs[4]  = '{"or",     5'b00110, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0};
    vecs[5]  = '{"shr",    5'b00111, 32'h80000000, 32'h00000004, 32'h08000000, 32'h0};
    vecs[6]  = '{"shra",   5'b01000, 32'h80000000, 32'h00000004, 32'hF8000000, 32'h0};
    vecs[7]  = '{"shl",    5'b01001, 32'h00000001, 32'h0000001F, 32'h80000000, 32'h0};
    vecs[8]  = '{"ror",    5'b01010, 32'h00000001, 32'h00000001, 32'h80000000, 32'h0};
    vecs[9]  = '{"rol",    5'b01011, 32'h80000001, 32'h00000024, 32'h00000018, 32'h0};
    vecs[10] = '{"mul_neg",5'b01111, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[11] = '{"mul_big",5'b01111, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001};
    vecs[12] = '{"neg",    5'b10000, 32'h00000009, 32'h00000005, 32'hFFFFFFFB, 32'h0};
    vecs[13] = '{"not",    5'b10001, 32'h00000009, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0};
    vecs[14] = '{"undef",  5'b11111, 32'h00000003, 32'h00000004, 32'h00000007, 32'h0};
    vecs[15] = '{"addi_wr",5'b01100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0};

    clear_ctl();
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_views_zero("rst0");
    clr = 1'b1;

    write_ram(32'h5, 32'hB6);
    write_ram(32'hEA, 32'h19);

    // PC count-up then copy into MAR
    PC_rd = 1; tick();
    repeat (5) begin IncPC = 1; tick(); end
    check("pc5", PC_view, 32'h5);
    PC_out = 1; MAR_rd = 1; tick();
    check("mar5", {23'd0, MAR_view}, 32'h5);

    // ld R3 from RAM[5]
    Read = 1; MDR_rd = 1; tick();
    check("mdr_rd", MDR_view, 32'hB6);
    MDR_out = 1; R_rd_diog = 16'h0008; #1;
    check("regctl_ld3", regControl_view, 32'h00000008);
    tick();
    check("r3", r3_view, 32'hB6);

    // st R3,0x34(R3)
    make_const(32'h11980034);
    Zlo_out = 1; MDR_rd = 1; tick();
    MDR_out = 1; IR_rd = 1; tick();
    check("ir_st", IR_view, 32'h11980034);
    check("cext_st", C_extended_view, 32'h00000034);
    Grb = 1; BAout = 1; R_out = 1; Y_rd = 1; #1;
    check("regctl_grb", regControl_view, 32'h00080000);
    check("bus_rb", BusMuxOut, 32'hB6);
    tick();
    check("y_base", Y_view, 32'hB6);
    C_out = 1; Zlo_rd = 1; #1;
    check("bus_c", BusMuxOut, 32'h34);
    tick();
    check("z_ea", Zlo_view, 32'hEA);
    Zlo_out = 1; MAR_rd = 1; tick();
    check("mar_ea", {23'd0, MAR_view}, 32'hEA);
    Gra = 1; R_out = 1; MDR_rd = 1; tick();
    check("mdr_ra", MDR_view, 32'hB6);
    Read = 1; Write = 1; MDR_rd = 1; tick();
    check("rbw_old", MDR_view, 32'h19);
    Read = 1; MDR_rd = 1; tick();
    check("ram_ea_new", MDR_view, 32'hB6);

    // BAout with Rb = 0 reads as zero even though R0 holds data
    MDR_out = 1; R_rd_diog = 16'h0001; tick();
    IR_rd = 1; tick();
    check("ir_zero", IR_view, 32'h0);
    Grb = 1; BAout = 1; Y_rd = 1; #1;
    check("bus_ba0", BusMuxOut, 32'h0);
    check("regctl_ba0", regControl_view, 32'h00010000);
    tick();
    check("y_ba0", Y_view, 32'h0);
    Grb = 1; R_out = 1; #1;
    check("bus_r0", BusMuxOut, 32'hB6);
    clear_ctl();
    make_const(32'h00040000);
    Zlo_out = 1; IR_rd = 1; tick();
    check("cext_neg", C_extended_view, 32'hFFFC0000);
    C_out = 1; #1;
    check("bus_cneg", BusMuxOut, 32'hFFFC0000);
    clear_ctl();

    // fetch increment and PC/MAR wrap
    make_const(32'h7);
    Zlo_out = 1; PC_rd = 1; tick();
    check("pc7", PC_view, 32'h7);
    PC_out = 1; IncPC = 1; Zlo_rd = 1; tick();
    check("z_inc", Zlo_view, 32'h8);
    Zlo_out = 1; PC_rd = 1; tick();
    check("pc8", PC_view, 32'h8);
    Zlo_out = 1; PC_rd = 1; IncPC = 1; tick();
    check("pc_rd_wins", PC_view, 32'h8);
    make_const(32'hFFFFFFFF);
    Zlo_out = 1; PC_rd = 1; tick();
    check("pc_max", PC_view, 32'hFFFFFFFF);
    IncPC = 1; tick();
    check("pc_wrap", PC_view, 32'h0);
    make_const(32'h000002EA);
    Zlo_out = 1; MAR_rd = 1; tick();
    check("mar_wrap", {23'd0, MAR_view}, 32'hEA);
    MAR_out = 1; #1;
    check("bus_mar", BusMuxOut, 32'hEA);
    clear_ctl();
    IR_rd = 1; tick();

    // ALU table: R1 = B, R2 = A, IR = opcode, Y <- R2, Z <- alu(Y, R1)
    for (int v = 0; v < 16; v++) begin
      make_const(vecs[v].b);
      Zlo_out = 1; R_rd_diog = 16'h0002; tick();
      make_const(vecs[v].a);
      Zlo_out = 1; R_rd_diog = 16'h0004; tick();
      make_const({vecs[v].op, 27'd0});
      Zlo_out = 1; IR_rd = 1; tick();
      R_wrt_diog = 16'h0004; Y_rd = 1; tick();
      R_wrt_diog = 16'h0002; Zlo_rd = 1; tick();
      check({vecs[v].name, " lo"}, Zlo_view, vecs[v].exp_lo);
      Zhi_out = 1; #1;
      check({vecs[v].name, " hi"}, BusMuxOut, vecs[v].exp_hi);
      clear_ctl();
      IR_rd = 1; tick();
    end

    // asynchronous clear mid-cycle, RAM must survive
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    check_views_zero("rst_mid");
    #2;
    clr = 1'b1;
    read_ram(32'h5);
    check("ram5_kept", MDR_view, 32'hB6);
    read_ram(32'hEA);
    check("ramEA_kept", MDR_view, 32'hB6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
